// File: rtl/gh_uart_pkg.sv
// Shared types for the UART receive sequencer.
// Holds the FSM state encoding and the word-length decode.
package gh_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int MIN_DATA_BITS = 5;

    function automatic logic [3:0] wlen_to_bits(input logic [1:0] wlen);
        return 4'(MIN_DATA_BITS) + {2'b00, wlen};
    endfunction

endpackage

// File: rtl/gh_uart_rx_seq_if.sv
// Receive-side bundle: shift register controls toward the SR,
// character status toward the receive FIFO logic.
interface gh_uart_rx_seq_if;
    import gh_uart_pkg::*;

    logic sr_se;
    logic sr_d;
    logic sr_srst;
    logic rx_valid;
    logic par_err;
    logic frm_err;
    logic brk_det;
    logic busy;

    modport master (
        output sr_se, sr_d, sr_srst,
        output rx_valid, par_err, frm_err, brk_det, busy
    );

    modport slave (
        input sr_se, sr_d, sr_srst,
        input rx_valid, par_err, frm_err, brk_det, busy
    );

endinterface

// File: rtl/gh_uart_rx_bit_sampler.sv
// Bit-window tick counter and sample strobe for the UART receiver.
// Define GH_UART_RX_MAJORITY_EN for a 2-of-3 vote around the sample tick.
module gh_uart_rx_bit_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic clk,
    input  logic rst,
    input  logic brclk,
    input  logic rxd,
    input  logic clr,
    input  logic half,
    output logic strobe,
    output logic sample
);
    import gh_uart_pkg::*;

    localparam logic [CNT_W-1:0] S_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] S_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] spt;

    assign spt    = half ? S_HALF : S_FULL;
    assign strobe = brclk && !clr && (cnt == spt);

    // Window restarts on the sample tick so bits follow back to back
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (brclk) begin
            if (clr || strobe) cnt <= '0;
            else               cnt <= cnt + 1'b1;
        end
    end

`ifdef GH_UART_RX_MAJORITY_EN
    logic [CNT_W-1:0] spt_m1;
    logic [CNT_W-1:0] spt_m2;
    logic             v0;
    logic             v1;

    assign spt_m1 = spt - CNT_W'(1);
    assign spt_m2 = spt - CNT_W'(2);

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (brclk) begin
            if (clr || strobe) begin
                v0 <= 1'b0;
                v1 <= 1'b0;
            end else begin
                if (cnt == spt_m2) v0 <= rxd;
                if (cnt == spt_m1) v1 <= rxd;
            end
        end
    end

    assign sample = (v0 & v1) | (v0 & rxd) | (v1 & rxd);
`else
    assign sample = rxd;
`endif

endmodule

// File: rtl/gh_uart_rx_seq.sv
// UART receive sequencer: start detect, mid-bit sampling, SR control.
// Optional GH_UART_RX_MAJORITY_EN selects 3-sample majority voting.
module gh_uart_rx_seq #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             brclk,
    input  logic             rxd,
    input  logic [1:0]       wlen,
    input  logic             par_en,
    input  logic             par_even,
    gh_uart_rx_seq_if.master rx
);
    import gh_uart_pkg::*;

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("OVERSAMPLE must be even and at least 8");
    end

    rx_state_t  st, st_n;
    logic [3:0] bcnt, bcnt_n;
    logic [3:0] nbits, nbits_n;
    logic       pen, pen_n;
    logic       peven, peven_n;
    logic       acc, acc_n;
    logic       zero, zero_n;
    logic       pbad, pbad_n;
    logic       armed, armed_n;

    logic se_q, se_n;
    logic d_q, d_n;
    logic srst_q, srst_n;
    logic vld_q, vld_n;
    logic perr_q, perr_n;
    logic ferr_q, ferr_n;
    logic brk_q, brk_n;

    logic strobe;
    logic sample;

    gh_uart_rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_smp (
        .clk    (clk),
        .rst    (rst),
        .brclk  (brclk),
        .rxd    (rxd),
        .clr    (st == IDLE),
        .half   (st == START),
        .strobe (strobe),
        .sample (sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            bcnt   <= '0;
            nbits  <= '0;
            pen    <= 1'b0;
            peven  <= 1'b0;
            acc    <= 1'b0;
            zero   <= 1'b0;
            pbad   <= 1'b0;
            armed  <= 1'b1;
            se_q   <= 1'b0;
            d_q    <= 1'b0;
            srst_q <= 1'b0;
            vld_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            st     <= st_n;
            bcnt   <= bcnt_n;
            nbits  <= nbits_n;
            pen    <= pen_n;
            peven  <= peven_n;
            acc    <= acc_n;
            zero   <= zero_n;
            pbad   <= pbad_n;
            armed  <= armed_n;
            se_q   <= se_n;
            d_q    <= d_n;
            srst_q <= srst_n;
            vld_q  <= vld_n;
            perr_q <= perr_n;
            ferr_q <= ferr_n;
            brk_q  <= brk_n;
        end
    end

    always_comb begin
        st_n    = st;
        bcnt_n  = bcnt;
        nbits_n = nbits;
        pen_n   = pen;
        peven_n = peven;
        acc_n   = acc;
        zero_n  = zero;
        pbad_n  = pbad;
        armed_n = armed;
        se_n    = 1'b0;
        d_n     = 1'b0;
        srst_n  = 1'b0;
        vld_n   = 1'b0;
        perr_n  = perr_q;
        ferr_n  = ferr_q;
        brk_n   = brk_q;

        if (brclk) begin
            unique case (st)
                IDLE: begin
                    // A low line only starts a frame once it was seen high
                    if (rxd)        armed_n = 1'b1;
                    else if (armed) st_n    = START;
                end
                START: begin
                    if (strobe) begin
                        if (!sample) begin
                            srst_n  = 1'b1;
                            acc_n   = 1'b0;
                            zero_n  = 1'b1;
                            pbad_n  = 1'b0;
                            bcnt_n  = '0;
                            nbits_n = wlen_to_bits(wlen);
                            pen_n   = par_en;
                            peven_n = par_even;
                            st_n    = DATA;
                        end else begin
                            st_n = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (strobe) begin
                        se_n   = 1'b1;
                        d_n    = sample;
                        acc_n  = acc ^ sample;
                        zero_n = zero & ~sample;
                        bcnt_n = bcnt + 4'd1;
                        if (bcnt + 4'd1 == nbits)
                            st_n = pen ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (strobe) begin
                        pbad_n = acc ^ sample ^ ~peven;
                        zero_n = zero & ~sample;
                        st_n   = STOP;
                    end
                end
                STOP: begin
                    if (strobe) begin
                        vld_n   = 1'b1;
                        perr_n  = pbad;
                        ferr_n  = ~sample;
                        brk_n   = zero & ~sample;
                        armed_n = sample;
                        st_n    = IDLE;
                    end
                end
                default: st_n = IDLE;
            endcase
        end
    end

    assign rx.sr_se    = se_q;
    assign rx.sr_d     = d_q;
    assign rx.sr_srst  = srst_q;
    assign rx.rx_valid = vld_q;
    assign rx.par_err  = perr_q;
    assign rx.frm_err  = ferr_q;
    assign rx.brk_det  = brk_q;
    assign rx.busy     = (st != IDLE);

endmodule

// File: doc/gh_uart_rx_seq.md
Name: gh_uart_rx_seq

Overview:
UART receive sequencer that drives the shift-enable serial-in shift register in the UART receive path.
- Detects the start bit, times each bit with a 16x baud tick and samples mid-bit.
- Pulses the shift register's se/srst controls and checks parity and stop bit.
- Reports a completed character with error flags to the receive FIFO logic.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit; must be even, minimum 8.
- CNT_W, $clog2(OVERSAMPLE), width of the tick counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- brclk  in  1  one-clk-wide 16x baud tick enable.
- rxd  in  1  serial input, already synchronized to clk; idle high.
- wlen  in  2  word length: 0=5, 1=6, 2=7, 3=8 data bits.
- par_en  in  1  parity bit present.
- par_even  in  1  1=even parity, 0=odd parity.
- sr_se  out  1  one-clk shift-enable pulse to the shift register.
- sr_d  out  1  sampled bit value, valid when sr_se=1.
- sr_srst  out  1  one-clk pulse that clears the shift register.
- rx_valid  out  1  one-clk pulse: character complete.
- par_err  out  1  parity error; valid with rx_valid.
- frm_err  out  1  stop bit sampled low; valid with rx_valid.
- brk_det  out  1  all bits including parity and stop were 0; valid with rx_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, tick counter 0, bit counter 0, parity accumulator 0.
  - All outputs 0.
  - rst takes priority over everything and aborts a character mid-frame with no rx_valid.
- The state and the counters advance only on clk edges where brclk=1. Output pulses last exactly one clk.
- IDLE:
  - On a brclk tick with rxd=0, go to START with the tick counter cleared to 0.
- START:
  - Tick counter increments on each brclk.
  - On the tick where the counter equals OVERSAMPLE/2-1 (the 8th tick after detection), test the sampled value.
  - Sampled 0: pulse sr_srst, clear the parity accumulator, go to DATA with the tick and bit counters cleared.
  - Sampled 1 (false start): return to IDLE with no outputs.
- DATA:
  - Tick counter runs 0..OVERSAMPLE-1 and wraps.
  - On the tick where the counter equals OVERSAMPLE-1:
    - sr_se=1 and sr_d=sample.
    - The parity accumulator XORs in the sample.
    - The bit counter increments.
  - After wlen+5 bits, go to PARITY if par_en=1, otherwise STOP.
- PARITY:
  - Same timing as one DATA bit, with no sr_se pulse.
  - par_err = accumulator XOR sample XOR (par_even ? 0 : 1).
  - In odd mode the total count of 1s must be odd.
  - Go to STOP.
- STOP:
  - Sample on the same tick position as a data bit.
  - rx_valid pulses on that clk.
  - frm_err = ~sample.
  - brk_det = 1 if every data, parity and stop sample was 0.
  - The error flags are held stable until the next rx_valid; reset clears them.
  - Go to IDLE on the same edge, so a start bit can be detected on the next brclk.
- wlen, par_en and par_even are sampled when leaving START and held for the whole character. Changing them mid-frame has no effect.
- rxd at 0 continuously: one character with frm_err=1 and brk_det=1. No new start is recognised until rxd has been seen 1 on at least one brclk tick in IDLE.
- Latency: rx_valid occurs 8 + 16*(wlen+5+par_en+1) brclk ticks after start detection, for OVERSAMPLE=16.

Optional Feature:
- Macro: GH_UART_RX_MAJORITY_EN.
- Defined:
  - Each sample is the 2-of-3 majority of rxd taken at tick positions S-2, S-1 and S, where S is the nominal sample tick.
  - Applies to the start confirmation and to every data, parity and stop bit.
  - Vote registers are cleared on entry to each bit window.
- Undefined: a single rxd value is taken at tick S; no vote registers are present.

Decomposition:
- Package gh_uart_pkg holds:
  - the state enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam MIN_DATA_BITS=5;
  - the wlen decode function wlen_to_bits.
- One sub-module, gh_uart_rx_bit_sampler, contains:
  - the tick counter;
  - the sample-point strobe;
  - the majority vote logic under the macro.
- The FSM lives in gh_uart_rx_seq.

Test Plan:
- 8N1, character 0x5A, brclk every 4 clk → 8 sr_se pulses with sr_d=0,1,0,1,1,0,1,0; one rx_valid; par_err=0, frm_err=0.
- 7E1, character 0x41, correct parity bit 0 → par_err=0; repeat with parity bit 1 → par_err=1.
- 8N1 with stop bit forced 0 → frm_err=1 and brk_det=0; full break of rxd=0 for 12 bit times → one rx_valid with brk_det=1 and no restart until rxd returns high.
- rxd low pulse of 4 ticks in IDLE → no sr_srst, no sr_se, back to IDLE; busy high for 8 ticks only.
- rst asserted mid-DATA after 3 bits → all outputs 0 on the next clk, no rx_valid; the next full character is received correctly.
- With GH_UART_RX_MAJORITY_EN: 1-tick glitch at tick S-1 of a data bit → sampled value unchanged; without the macro, the same glitch at tick S → sample flips.
